muldiv_unit: RTL

//  Parametrised iterative multiply/divide unit with architectural HI/LO registers for the 5-stage core.

---
 rtl/muldiv_unit_if.sv | 21 ++
 rtl/muldiv_unit.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
// The core side uses master; the unit uses slave.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, flush,
                    input  busy, done, div_zero, hi, lo);
    modport slave  (input  start, op, a, b, flush,
                    output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with architectural HI/LO.
// Ops run on magnitudes; the final FIX state applies signs and writes HI/LO.
module muldiv_unit #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   opB;
    logic [CW-1:0]      cnt;
    logic               sa, sb, isDiv, dz;

    logic               signedOp, aNeg, bNeg;
    logic [WIDTH:0]     mulSum, divTrial;
    logic               divGe;
    logic [WIDTH-1:0]   divDiff, quo, rem, fixHi, fixLo;
    logic [2*WIDTH-1:0] prodNeg;

    function automatic logic [WIDTH-1:0] absVal(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    always_comb begin
        signedOp = SIGNED_EN && (bus.op == 3'd0 || bus.op == 3'd2);
        aNeg     = signedOp & bus.a[WIDTH-1];
        bNeg     = signedOp & bus.b[WIDTH-1];

        mulSum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opB} : '0);
        // Partial remainder shifted left with the next dividend bit; the low
        // WIDTH bits of the difference are exact whenever the trial succeeds.
        divTrial = prod[2*WIDTH-1:WIDTH-1];
        divGe    = divTrial >= {1'b0, opB};
        divDiff  = divTrial[WIDTH-1:0] - opB;

        prodNeg  = -prod;
        quo      = prod[WIDTH-1:0];
        rem      = prod[2*WIDTH-1:WIDTH];
        fixHi    = '0;
        fixLo    = '0;
        if (dz) begin
            fixHi = prod[WIDTH-1:0];
            fixLo = '1;
        end else if (isDiv) begin
            fixLo = (sa ^ sb) ? -quo : quo;
            fixHi = sa ? -rem : rem;
        end else if (sa ^ sb) begin
            {fixHi, fixLo} = prodNeg;
        end else begin
            {fixHi, fixLo} = prod;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            prod         <= '0;
            opB          <= '0;
            cnt          <= '0;
            sa           <= 1'b0;
            sb           <= 1'b0;
            isDiv        <= 1'b0;
            dz           <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.div_zero <= 1'b0;
            bus.hi       <= '0;
            bus.lo       <= '0;
        end else begin
            bus.done <= 1'b0;
            if (bus.flush) begin
                state    <= IDLE;
                bus.busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            case (bus.op)
                                3'd0, 3'd1, 3'd2, 3'd3: begin
                                    bus.div_zero <= 1'b0;
                                    bus.busy     <= 1'b1;
                                    isDiv        <= bus.op[1];
                                    sa           <= aNeg;
                                    sb           <= bNeg;
                                    opB          <= absVal(bus.b, bNeg);
                                    cnt          <= CW'(WIDTH);
                                    if (bus.op[1] && bus.b == '0) begin
                                        // Raw dividend kept for HI on divide-by-zero
                                        dz    <= 1'b1;
                                        prod  <= {{WIDTH{1'b0}}, bus.a};
                                        state <= FIX;
                                    end else begin
                                        dz    <= 1'b0;
                                        prod  <= {{WIDTH{1'b0}}, absVal(bus.a, aNeg)};
                                        state <= bus.op[1] ? DIV : MUL;
                                    end
                                end
                                3'd4: begin
                                    bus.div_zero <= 1'b0;
                                    bus.hi       <= bus.a;
                                end
                                3'd5: begin
                                    bus.div_zero <= 1'b0;
                                    bus.lo       <= bus.a;
                                end
                                default: ;
                            endcase
                        end
                    end
                    MUL: begin
                        prod <= {mulSum, prod[WIDTH-1:1]};
                        cnt  <= cnt - 1'b1;
                        if (cnt == CW'(1)) state <= FIX;
                    end
                    DIV: begin
                        prod <= {divGe ? divDiff : divTrial[WIDTH-1:0], prod[WIDTH-2:0], divGe};
                        cnt  <= cnt - 1'b1;
                        if (cnt == CW'(1)) state <= FIX;
                    end
                    FIX: begin
                        bus.hi       <= fixHi;
                        bus.lo       <= fixLo;
                        bus.div_zero <= dz;
                        bus.done     <= 1'b1;
                        bus.busy     <= 1'b0;
                        state        <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
